// File: rtl/te_commit_window.sv
// Trace-encoder front end: buffers up to two commits per cycle in an in-order
// FIFO and serialises them one per cycle into a pc/cc/nc instruction window.
module te_commit_window #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     valid_i,
  input  logic [1:0][XLEN-1:0]           iaddr_i,
  input  logic [1:0][XLEN-1:0]           inst_data_i,
  input  logic [1:0]                     compressed_i,
  input  logic [1:0]                     exception_i,
  input  logic [1:0]                     interrupt_i,
  input  logic [1:0]                     eret_i,
  input  logic                           flush_i,
  output logic                           pc_valid_o,
  output logic                           cc_valid_o,
  output logic                           nc_valid_o,
  output logic [XLEN-1:0]                pc_iaddr_o,
  output logic [XLEN-1:0]                cc_iaddr_o,
  output logic [XLEN-1:0]                nc_iaddr_o,
  output logic [XLEN-1:0]                cc_inst_data_o,
  output logic                           cc_compressed_o,
  output logic                           cc_exception_o,
  output logic                           cc_interrupt_o,
  output logic                           cc_eret_o,
  output logic                           step_o,
  output logic                           overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] inst_data;
    logic            compressed;
    logic            exception;
    logic            interrupt;
    logic            eret;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          mem_d [FIFO_DEPTH];
  entry_t          cc_q, cc_d, nc_q, nc_d;
  logic [XLEN-1:0] pc_iaddr_q, pc_iaddr_d;
  logic            pc_valid_q, pc_valid_d;
  logic            cc_valid_q, cc_valid_d;
  logic            nc_valid_q, nc_valid_d;
  logic            step_q, step_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;

  entry_t          in_e [2];
  logic [CW-1:0]   nwr;
  logic [CW-1:0]   free;
  logic            accept;
  logic            pop;
  logic [PW-1:0]   wptr_nxt;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      in_e[p] = '{iaddr: iaddr_i[p], inst_data: inst_data_i[p],
                  compressed: compressed_i[p], exception: exception_i[p],
                  interrupt: interrupt_i[p], eret: eret_i[p]};
    end
    nwr      = CW'(valid_i[0]) + CW'(valid_i[1]);
    free     = CW'(FIFO_DEPTH) - cnt_q;
    // Space check uses the registered count only; a same-cycle pop is not credited.
    accept   = (free >= nwr);
    pop      = (cnt_q != '0);
    wptr_nxt = wptr_q + PW'(1);

    mem_d      = mem_q;
    cc_d       = cc_q;
    nc_d       = nc_q;
    pc_iaddr_d = pc_iaddr_q;
    pc_valid_d = pc_valid_q;
    cc_valid_d = cc_valid_q;
    nc_valid_d = nc_valid_q;
    step_d     = 1'b0;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (flush_i) begin
      // Window address/data deliberately left intact; only valids are cleared.
      pc_valid_d = 1'b0;
      cc_valid_d = 1'b0;
      nc_valid_d = 1'b0;
      ovf_d      = 1'b0;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end else begin
      if (accept) begin
        unique case (valid_i)
          2'b01: mem_d[wptr_q] = in_e[0];
          2'b10: mem_d[wptr_q] = in_e[1];
          2'b11: begin
            mem_d[wptr_q]   = in_e[0];
            mem_d[wptr_nxt] = in_e[1];
          end
          default: ;
        endcase
        wptr_d = wptr_q + PW'(nwr);
      end else begin
        ovf_d = 1'b1;
      end

      if (pop) begin
        pc_iaddr_d = cc_q.iaddr;
        pc_valid_d = cc_valid_q;
        cc_d       = nc_q;
        cc_valid_d = nc_valid_q;
        nc_d       = mem_q[rptr_q];
        nc_valid_d = 1'b1;
        rptr_d     = rptr_q + PW'(1);
        step_d     = 1'b1;
      end

      cnt_d = cnt_q + (accept ? nwr : '0) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q       <= '0;
      nc_q       <= '0;
      pc_iaddr_q <= '0;
      pc_valid_q <= 1'b0;
      cc_valid_q <= 1'b0;
      nc_valid_q <= 1'b0;
      step_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      cc_q       <= cc_d;
      nc_q       <= nc_d;
      pc_iaddr_q <= pc_iaddr_d;
      pc_valid_q <= pc_valid_d;
      cc_valid_q <= cc_valid_d;
      nc_valid_q <= nc_valid_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  assign pc_valid_o      = pc_valid_q;
  assign cc_valid_o      = cc_valid_q;
  assign nc_valid_o      = nc_valid_q;
  assign pc_iaddr_o      = pc_iaddr_q;
  assign cc_iaddr_o      = cc_q.iaddr;
  assign nc_iaddr_o      = nc_q.iaddr;
  assign cc_inst_data_o  = cc_q.inst_data;
  assign cc_compressed_o = cc_q.compressed;
  assign cc_exception_o  = cc_q.exception;
  assign cc_interrupt_o  = cc_q.interrupt;
  assign cc_eret_o       = cc_q.eret;
  assign step_o          = step_q;
  assign overflow_o      = ovf_q;
  assign fifo_count_o    = cnt_q;

endmodule

// File: tb/tb_te_commit_window.sv
// Directed bench for te_commit_window: stream, dual ordering, overflow, flush,
// port-1-only and asynchronous reset scenarios with hand-computed expectations.
module tb_te_commit_window;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [1:0]           valid = '0;
  logic [1:0][XLEN-1:0] iaddr = '0;
  logic [1:0][XLEN-1:0] idata = '0;
  logic [1:0]           comp = '0, exc = '0, intr = '0, eret = '0;
  logic                 flush = 1'b0;
  logic                 pc_v, cc_v, nc_v;
  logic [XLEN-1:0]      pc_a, cc_a, nc_a, cc_d;
  logic                 cc_c, cc_e, cc_i, cc_r;
  logic                 step, ovf;
  logic [3:0]           cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  te_commit_window #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .iaddr_i(iaddr),
    .inst_data_i(idata), .compressed_i(comp), .exception_i(exc),
    .interrupt_i(intr), .eret_i(eret), .flush_i(flush),
    .pc_valid_o(pc_v), .cc_valid_o(cc_v), .nc_valid_o(nc_v),
    .pc_iaddr_o(pc_a), .cc_iaddr_o(cc_a), .nc_iaddr_o(nc_a),
    .cc_inst_data_o(cc_d), .cc_compressed_o(cc_c), .cc_exception_o(cc_e),
    .cc_interrupt_o(cc_i), .cc_eret_o(cc_r), .step_o(step),
    .overflow_o(ovf), .fifo_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction data is the inverted address so data checks are self-evident.
  task automatic drive(input logic [1:0] v, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a1);
    valid    = v;
    iaddr[0] = a0;
    iaddr[1] = a1;
    idata[0] = ~a0;
    idata[1] = ~a1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_pc_v"}, 64'(pc_v), 64'd0);
    check_eq({pfx, "_cc_v"}, 64'(cc_v), 64'd0);
    check_eq({pfx, "_nc_v"}, 64'(nc_v), 64'd0);
    check_eq({pfx, "_pc_a"}, 64'(pc_a), 64'd0);
    check_eq({pfx, "_cc_a"}, 64'(cc_a), 64'd0);
    check_eq({pfx, "_nc_a"}, 64'(nc_a), 64'd0);
    check_eq({pfx, "_cc_d"}, 64'(cc_d), 64'd0);
    check_eq({pfx, "_cc_attr"}, 64'({cc_c, cc_e, cc_i, cc_r}), 64'd0);
    check_eq({pfx, "_step"}, 64'(step), 64'd0);
    check_eq({pfx, "_ovf"}, 64'(ovf), 64'd0);
    check_eq({pfx, "_cnt"}, 64'(cnt), 64'd0);
  endtask

  logic [XLEN-1:0] dual_exp [4];

  initial begin
    // Reset
    #1 rst = 1'b1;
    #2 check_reset_vals("rst");
    tick();
    tick();
    rst = 1'b0;

    // Single stream on port 0
    drive(2'b01, 32'h8000_0000, '0);
    tick();
    check_eq("ss_cnt1", 64'(cnt), 64'd1);
    check_eq("ss_step1", 64'(step), 64'd0);
    drive(2'b01, 32'h8000_0004, '0);
    tick();
    check_eq("ss_step2", 64'(step), 64'd1);
    check_eq("ss_nc2", 64'(nc_a), 64'h8000_0000);
    drive(2'b01, 32'h8000_0008, '0);
    tick();
    check_eq("ss_step3", 64'(step), 64'd1);
    check_eq("ss_nc3", 64'(nc_a), 64'h8000_0004);
    check_eq("ss_cc3", 64'(cc_a), 64'h8000_0000);
    drive(2'b00, '0, '0);
    tick();
    check_eq("ss_step4", 64'(step), 64'd1);
    check_eq("ss_pc", 64'(pc_a), 64'h8000_0000);
    check_eq("ss_cc", 64'(cc_a), 64'h8000_0004);
    check_eq("ss_nc", 64'(nc_a), 64'h8000_0008);
    check_eq("ss_valids", 64'({pc_v, cc_v, nc_v}), 64'b111);
    check_eq("ss_cc_data", 64'(cc_d), 64'h7FFF_FFFB);
    check_eq("ss_cnt_end", 64'(cnt), 64'd0);
    tick();
    check_eq("ss_step_idle", 64'(step), 64'd0);

    // Dual commit ordering; B's port 1 carries an exception flag
    drive(2'b11, 32'h0000_A000, 32'h0000_A004);
    tick();
    check_eq("dual_cnt2", 64'(cnt), 64'd2);
    check_eq("dual_step0", 64'(step), 64'd0);
    drive(2'b11, 32'h0000_B000, 32'h0000_B004);
    exc = 2'b10;
    tick();
    exc = 2'b00;
    check_eq("dual_cnt3", 64'(cnt), 64'd3);
    check_eq("dual_nc_a0", 64'(nc_a), 64'h0000_A000);
    drive(2'b11, 32'h0000_C000, 32'h0000_C004);
    tick();
    check_eq("dual_cnt4", 64'(cnt), 64'd4);
    check_eq("dual_nc_a1", 64'(nc_a), 64'h0000_A004);
    check_eq("dual_cc_a0", 64'(cc_a), 64'h0000_A000);
    check_eq("dual_cc_d_a0", 64'(cc_d), 64'hFFFF_5FFF);
    drive(2'b00, '0, '0);
    dual_exp[0] = 32'h0000_B000;
    dual_exp[1] = 32'h0000_B004;
    dual_exp[2] = 32'h0000_C000;
    dual_exp[3] = 32'h0000_C004;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("dual_nc%0d", i), 64'(nc_a), 64'(dual_exp[i]));
      check_eq($sformatf("dual_cnt_drain%0d", i), 64'(cnt), 64'(3 - i));
      check_eq($sformatf("dual_step%0d", i), 64'(step), 64'd1);
      if (i == 1) check_eq("dual_cc_exc_b0", 64'(cc_e), 64'd0);
      if (i == 2) check_eq("dual_cc_exc_b1", 64'(cc_e), 64'd1);
    end
    tick();
    check_eq("dual_step_idle", 64'(step), 64'd0);

    // Fill to 7, then an unfittable dual commit must be dropped whole
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 32'h100 + 32'(i * 8), 32'h104 + 32'(i * 8));
      tick();
      check_eq($sformatf("ovf_fill%0d", i), 64'(cnt), 64'(i + 2));
    end
    check_eq("ovf_pre", 64'(ovf), 64'd0);
    drive(2'b11, 32'hBAD0, 32'hBAD4);
    tick();
    check_eq("ovf_cnt_drop", 64'(cnt), 64'd6);
    check_eq("ovf_set", 64'(ovf), 64'd1);
    drive(2'b01, 32'h200, '0);
    tick();
    check_eq("ovf_cnt_after", 64'(cnt), 64'd6);
    check_eq("ovf_sticky1", 64'(ovf), 64'd1);
    drive(2'b00, '0, '0);
    tick();
    check_eq("ovf_cnt5", 64'(cnt), 64'd5);
    check_eq("ovf_sticky2", 64'(ovf), 64'd1);

    // Flush at count 5 with a dual commit in the same cycle
    drive(2'b11, 32'hF000, 32'hF004);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(2'b00, '0, '0);
    check_eq("fl_cnt", 64'(cnt), 64'd0);
    check_eq("fl_valids", 64'({pc_v, cc_v, nc_v}), 64'b000);
    check_eq("fl_ovf", 64'(ovf), 64'd0);
    check_eq("fl_step", 64'(step), 64'd0);
    tick();
    check_eq("fl_cnt_idle", 64'(cnt), 64'd0);
    check_eq("fl_step_idle", 64'(step), 64'd0);
    check_eq("fl_nc_v_idle", 64'(nc_v), 64'd0);

    // Port 1 only
    drive(2'b10, 32'hDEAD, 32'h1000);
    tick();
    check_eq("p1_cnt", 64'(cnt), 64'd1);
    check_eq("p1_step0", 64'(step), 64'd0);
    drive(2'b00, '0, '0);
    tick();
    check_eq("p1_step1", 64'(step), 64'd1);
    check_eq("p1_nc", 64'(nc_a), 64'h1000);
    check_eq("p1_valids", 64'({pc_v, cc_v, nc_v}), 64'b001);
    check_eq("p1_cnt0", 64'(cnt), 64'd0);

    // Asynchronous reset at count 4, between edges
    drive(2'b11, 32'h300, 32'h304);
    tick();
    drive(2'b11, 32'h308, 32'h30C);
    tick();
    drive(2'b11, 32'h310, 32'h314);
    tick();
    check_eq("ar_cnt4", 64'(cnt), 64'd4);
    drive(2'b00, '0, '0);
    #3 rst = 1'b1;
    #1 check_reset_vals("ar");
    tick();
    rst = 1'b0;
    tick();
    check_eq("ar_cnt_post", 64'(cnt), 64'd0);
    check_eq("ar_step_post", 64'(step), 64'd0);
    check_eq("ar_nc_v_post", 64'(nc_v), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
